// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, responder count and router state encoding.
package axil_pkg;

    localparam int unsigned NUM_SLV = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        RESP,
        ERR_W,
        ERR_B
    } state_t;

endpackage

// File: rtl/axil_addr_decode.sv
// Address region decode: compares the address tag against each responder base.
module axil_addr_decode
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned REGION_BITS = 12,
    parameter logic [ADDR_WIDTH-1:0] SLV0_BASE = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] SLV1_BASE = 32'h0000_1000,
    parameter logic [ADDR_WIDTH-1:0] SLV2_BASE = 32'h0000_2000,
    parameter logic [ADDR_WIDTH-1:0] SLV3_BASE = 32'h0000_3000
) (
    input  logic [ADDR_WIDTH-REGION_BITS-1:0] addr_tag,
    output logic [NUM_SLV-1:0]                sel,
    output logic                              decerr
);

    localparam int unsigned TAG_W = ADDR_WIDTH - REGION_BITS;

    localparam logic [NUM_SLV-1:0][TAG_W-1:0] BASE_TAG = {
        SLV3_BASE[ADDR_WIDTH-1:REGION_BITS],
        SLV2_BASE[ADDR_WIDTH-1:REGION_BITS],
        SLV1_BASE[ADDR_WIDTH-1:REGION_BITS],
        SLV0_BASE[ADDR_WIDTH-1:REGION_BITS]
    };

    // Scan from the top so the lowest matching index wins on overlap
    always_comb begin
        sel = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (addr_tag == BASE_TAG[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
        decerr = (sel == '0);
    end

endmodule

// File: rtl/axil_write_demux.sv
// 1-to-4 AXI4-Lite write router; one outstanding write, unmapped addresses end in DECERR.
module axil_write_demux
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned REGION_BITS = 12,
    parameter logic [ADDR_WIDTH-1:0] SLV0_BASE = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] SLV1_BASE = 32'h0000_1000,
    parameter logic [ADDR_WIDTH-1:0] SLV2_BASE = 32'h0000_2000,
    parameter logic [ADDR_WIDTH-1:0] SLV3_BASE = 32'h0000_3000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [NUM_SLV-1:0]        m_awvalid,
    input  logic [NUM_SLV-1:0]        m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic [NUM_SLV-1:0]        m_wvalid,
    input  logic [NUM_SLV-1:0]        m_wready,
    input  logic [2*NUM_SLV-1:0]      m_bresp,
    input  logic [NUM_SLV-1:0]        m_bvalid,
    output logic [NUM_SLV-1:0]        m_bready
);

    state_t               state_q, state_d;
    logic [NUM_SLV-1:0]   sel_q;
    logic [NUM_SLV-1:0]   dec_sel;
    logic                 dec_err;
    logic                 aw_done_q, w_done_q;
    logic                 aw_hs, w_hs;
    logic                 sel_bvalid;
    logic [1:0]           sel_bresp;

    axil_addr_decode #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .REGION_BITS (REGION_BITS),
        .SLV0_BASE   (SLV0_BASE),
        .SLV1_BASE   (SLV1_BASE),
        .SLV2_BASE   (SLV2_BASE),
        .SLV3_BASE   (SLV3_BASE)
    ) u_decode (
        .addr_tag (s_awaddr[ADDR_WIDTH-1:REGION_BITS]),
        .sel      (dec_sel),
        .decerr   (dec_err)
    );

    assign m_wdata = s_wdata;
    assign m_wstrb = s_wstrb;

    // B channel of the selected responder; unselected responders are never looked at
    always_comb begin
        sel_bvalid = 1'b0;
        sel_bresp  = RESP_OKAY;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) begin
                sel_bvalid = m_bvalid[i];
                sel_bresp  = m_bresp[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bresp   = RESP_OKAY;
        m_awvalid = '0;
        m_wvalid  = '0;
        m_bready  = '0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        case (state_q)
            IDLE: begin
                s_awready = ~rst;
                if (s_awvalid) begin
                    state_d = dec_err ? ERR_W : FWD;
                end
            end
            FWD: begin
                m_awvalid = sel_q & {NUM_SLV{~aw_done_q}};
                m_wvalid  = sel_q & {NUM_SLV{s_wvalid & ~w_done_q}};
                s_wready  = (|(m_wready & sel_q)) & ~w_done_q;
                aw_hs     = |(m_awvalid & m_awready);
                w_hs      = s_wvalid & s_wready;
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                s_bvalid = sel_bvalid;
                s_bresp  = sel_bresp;
                m_bready = sel_q & {NUM_SLV{s_bready}};
                if (sel_bvalid && s_bready) begin
                    state_d = IDLE;
                end
            end
            ERR_W: begin
                s_wready = 1'b1;
                if (s_wvalid) begin
                    state_d = ERR_B;
                end
            end
            ERR_B: begin
                s_bvalid = 1'b1;
                s_bresp  = RESP_DECERR;
                if (s_bready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            m_awaddr  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && s_awvalid) begin
                m_awaddr <= s_awaddr;
                sel_q    <= dec_sel;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (state_q == RESP && state_d == IDLE) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
        end
    end

endmodule
